// File: rtl/multi_mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// state codes, opcodes, datapath select encodings and the control bundle.
package multi_mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multi_mips_ctrl_outdec.sv
// Moore output decode for the multi-cycle control FSM, with the
// mem_ready/op gating and the reset-time suppression of write strobes.
module multi_mips_outdec
    import multi_mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    input  logic       reset,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.illegal = !op_legal(op);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.aluop    = ALU_SUB;
                ctrl.pcsource = PC_ALUOUT;
                ctrl.branch   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsource = PC_JUMP;
                ctrl.pcwrite  = 1'b1;
            end
            default: ctrl = '0;
        endcase

        // Reset must not let a half-finished access or writeback escape.
        if (reset) begin
            ctrl.pcwrite  = 1'b0;
            ctrl.branch   = 1'b0;
            ctrl.irwrite  = 1'b0;
            ctrl.regwrite = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.illegal  = 1'b0;
        end
    end

endmodule

// File: rtl/multi_mips_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// transitions and retired-instruction counter.
module multi_mips_ctrl
    import multi_mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             branch,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl;
    logic   retire;

    always_comb begin
        nxt = S_FETCH;
        unique case (cur)
            S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nxt = S_FETCH;
            S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    nxt = S_RTYPEWB;
            S_RTYPEWB: nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            S_ADDIEX:  nxt = S_ADDIWB;
            S_ADDIWB:  nxt = S_FETCH;
            S_JUMP:    nxt = S_FETCH;
            default:   nxt = S_FETCH;
        endcase
    end

    // Every path back to FETCH, including the illegal one, retires.
    assign retire = (cur != S_FETCH) && (nxt == S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    multi_mips_outdec u_outdec (
        .state     (cur),
        .op        (op),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;
    assign iord     = ctrl.iord;
    assign memread  = ctrl.memread;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsource = ctrl.pcsource;
    assign illegal  = ctrl.illegal;
    assign state    = cur;

endmodule

// File: tb/tb_multi_mips_ctrl.sv
// Directed bench for multi_mips_ctrl: a 32-bit counter instance plus a
// 4-bit counter instance sharing stimulus for the wrap case.
module tb_multi_mips_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        mem_ready;

    logic        pcwrite, branch, iord, memread, memwrite, irwrite;
    logic        memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0]  alusrcb, aluop, pcsource;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        pcwrite4, branch4, iord4, memread4, memwrite4, irwrite4;
    logic        memtoreg4, regdst4, regwrite4, alusrca4, illegal4;
    logic [1:0]  alusrcb4, aluop4, pcsource4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multi_mips_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal(illegal), .state(state),
        .retired(retired)
    );

    multi_mips_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite4), .branch(branch4), .iord(iord4),
        .memread(memread4), .memwrite(memwrite4), .irwrite(irwrite4),
        .memtoreg(memtoreg4), .regdst(regdst4), .regwrite(regwrite4),
        .alusrca(alusrca4), .alusrcb(alusrcb4), .aluop(aluop4),
        .pcsource(pcsource4), .illegal(illegal4), .state(state4),
        .retired(retired4)
    );

    task automatic test_reset();
        int st [4] = '{0, 1, 2, 5};
        int mr [4] = '{1, 1, 1, 0};
        reset = 1'b1; op = 6'h00; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (irwrite !== 1'b0 || pcwrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes: irwrite=%b pcwrite=%b want 0 0", irwrite, pcwrite);
        end
        checks++;
        if (state !== 4'd0 || retired !== 32'd0 || memread !== 1'b1) begin
            errors++;
            $display("FAIL rst_state: state=%0d ret=%0d memread=%b want 0 0 1", state, retired, memread);
        end
        @(negedge clk);
        reset = 1'b0; op = 6'h2B;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i][0];
            #1;
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL rst_sw_state c%0d: got %0d want %0d", i, state, st[i]);
            end
            if (i < 3) @(negedge clk);
        end
        checks++;
        if (memwrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_memwr_before: memwrite=%b want 1", memwrite);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (memwrite !== 1'b0 || state !== 4'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: memwrite=%b state=%0d ret=%0d want 0 0 0", memwrite, state, retired);
        end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || retired !== 32'd0 || memread !== 1'b1 || iord !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: state=%0d ret=%0d memread=%b iord=%b want 0 0 1 0", state, retired, memread, iord);
        end
        exp_ret = 0;
        @(negedge clk);
    endtask

    task automatic test_rtype();
        int st [4] = '{0, 1, 6, 7};
        op = 6'h00; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL rtype_state c%0d: got %0d want %0d", i, state, st[i]);
            end
            checks++;
            if (regwrite !== (st[i] == 7) || regdst !== (st[i] == 7)) begin
                errors++;
                $display("FAIL rtype_wb c%0d: regwrite=%b regdst=%b want %b", i, regwrite, regdst, st[i] == 7);
            end
            if (st[i] == 6) begin
                checks++;
                if (aluop !== 2'd2 || alusrca !== 1'b1 || alusrcb !== 2'd0) begin
                    errors++;
                    $display("FAIL rtype_exec: aluop=%0d srca=%b srcb=%0d want 2 1 0", aluop, alusrca, alusrcb);
                end
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + 1;
        #1;
        checks++;
        if (state !== 4'd0 || retired !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL rtype_retire: state=%0d ret=%0d want 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_lw_stall();
        int st [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        int mr [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        op = 6'h23;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i][0];
            #1;
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL lw_state c%0d: got %0d want %0d", i, state, st[i]);
            end
            if (st[i] == 3) begin
                checks++;
                if (memread !== 1'b1 || iord !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_memrd c%0d: memread=%b iord=%b want 1 1", i, memread, iord);
                end
            end
            if (st[i] == 4) begin
                checks++;
                if (memtoreg !== 1'b1 || regwrite !== 1'b1 || regdst !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_memwb: memtoreg=%b regwrite=%b regdst=%b want 1 1 0", memtoreg, regwrite, regdst);
                end
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + 1;
        #1;
        checks++;
        if (state !== 4'd0 || retired !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL lw_retire: state=%0d ret=%0d want 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_back_to_back();
        int st [10] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 11};
        logic [5:0] ops [10] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B,
                                 6'h04, 6'h04, 6'h04,
                                 6'h02, 6'h02, 6'h02};
        int wr_cycles = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = ops[i];
            #1;
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL b2b_state c%0d: got %0d want %0d", i, state, st[i]);
            end
            if (memwrite === 1'b1) wr_cycles++;
            checks++;
            if (branch !== (st[i] == 8) || pcwrite !== (st[i] == 0 || st[i] == 11)) begin
                errors++;
                $display("FAIL b2b_pc c%0d: branch=%b pcwrite=%b", i, branch, pcwrite);
            end
            if (st[i] == 8) begin
                checks++;
                if (aluop !== 2'd1 || pcsource !== 2'd1) begin
                    errors++;
                    $display("FAIL b2b_beq: aluop=%0d pcsource=%0d want 1 1", aluop, pcsource);
                end
            end
            if (st[i] == 11) begin
                checks++;
                if (pcsource !== 2'd2) begin
                    errors++;
                    $display("FAIL b2b_j: pcsource=%0d want 2", pcsource);
                end
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + 3;
        #1;
        checks++;
        if (wr_cycles != 1) begin
            errors++;
            $display("FAIL b2b_sw_memwrite: cycles=%0d want 1", wr_cycles);
        end
        checks++;
        if (state !== 4'd0 || retired !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL b2b_retire: state=%0d ret=%0d want 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        int st [2] = '{0, 1};
        op = 6'h3F; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (state !== 4'(st[i]) || illegal !== (st[i] == 1)) begin
                errors++;
                $display("FAIL illegal c%0d: state=%0d illegal=%b want %0d %b", i, state, illegal, st[i], st[i] == 1);
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + 1;
        #1;
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || retired !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL illegal_retire: state=%0d illegal=%b ret=%0d want 0 0 %0d", state, illegal, retired, exp_ret);
        end
    endtask

    task automatic test_fetch_stall();
        int st [3] = '{0, 1, 11};
        op = 6'h02; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== 4'd0 || irwrite !== 1'b0 || pcwrite !== 1'b0 || retired !== 32'(exp_ret)) begin
                errors++;
                $display("FAIL stall c%0d: state=%0d irwrite=%b pcwrite=%b ret=%0d", i, state, irwrite, pcwrite, retired);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 4'(st[i]) || irwrite !== (st[i] == 0)) begin
                errors++;
                $display("FAIL stall_go c%0d: state=%0d irwrite=%b want %0d", i, state, irwrite, st[i]);
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + 1;
        #1;
        checks++;
        if (retired !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL stall_retire: ret=%0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; op = 6'h02; mem_ready = 1'b1;
        repeat (45) @(negedge clk);
        #1;
        checks++;
        if (retired4 !== 4'hF || state4 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_pre: ret4=%0d state4=%0d want 15 0", retired4, state4);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (retired4 !== 4'h0) begin
            errors++;
            $display("FAIL wrap: ret4=%0d want 0", retired4);
        end
        checks++;
        if (retired !== 32'd16) begin
            errors++;
            $display("FAIL wrap_wide: ret=%0d want 16", retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_illegal();
        test_fetch_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
